vga_frame_fetcher: RTL and testbench

Reads the framebuffer that the serial-fed SDRAM writer fills and streams it out as 32-bit words for VGA scan-out. It issues burst read requests to the SDRAM controller on mem_clk and uses the same req/ack/idle/data_next handshake as the writer port. Each returned word is pushed into an external mem_clk→pixel_clk dual-clock FIFO, and fetching is throttled by that FIFO's fill level. Fetch restarts at the frame base address on every frame_start pulse, which is synchronised to vsync upstream.

---
 rtl/vga_frame_fetcher.sv | 227 ++++++++++++++++++++++
 tb/tb_vga_frame_fetcher.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_frame_fetcher.sv
// vga_frame_fetcher
//   Streams one framebuffer out of SDRAM as 32-bit words for VGA scan-out.
//   Issues BURST_LEN-word read requests over the req/ack/idle/data_next
//   handshake, pushes every returned word into a downstream dual-clock FIFO,
//   and throttles new requests on that FIFO's write-side fill level.
//   A frame_start pulse restarts the fetch at BASE_ADDR; a burst already
//   issued cannot be aborted, so its remaining words are drained silently
//   before the restart takes effect.
//
// Ports
//   mem_clk        system/SDRAM clock
//   reset          synchronous, active-high
//   frame_start    one-cycle pulse, restart fetch at BASE_ADDR
//   mem_idle       controller can accept a request
//   mem_ack        request accepted (one-cycle pulse)
//   mem_data_next  read word valid on mem_rd_data
//   mem_rd_data    read data from controller
//   mem_rd_addr    word address of the current request
//   mem_rd_req     read request (level, held until mem_ack)
//   fifo_usedw     write-side fill level of the downstream FIFO
//   pix_data       word to the FIFO
//   pix_wr         FIFO write strobe
//   fifo_clr       one-cycle flush pulse to the FIFO
//   frame_done     whole frame fetched, waiting for frame_start
//   err_stray      sticky: mem_data_next seen outside a burst
//
// State       | meaning
// ------------+---------------------------------------------------------
// IDLE        | after reset, waiting for the first frame_start
// WAIT_SPACE  | waiting for the FIFO to drop below FILL_LIMIT
// WAIT_IDLE   | room available, waiting for the controller to be idle
// REQ         | mem_rd_req asserted, waiting for mem_ack
// READ        | collecting the BURST_LEN words of the accepted burst
// DONE        | frame complete, frame_done high, waiting for frame_start

module vga_frame_fetcher #(
  parameter logic [24:0] BASE_ADDR   = 25'h0000000,
  parameter int          FRAME_WORDS = 153600,
  parameter int          BURST_LEN   = 8,
  parameter int          FILL_LIMIT  = 1000
) (
  input  logic        mem_clk,
  input  logic        reset,
  input  logic        frame_start,
  input  logic        mem_idle,
  input  logic        mem_ack,
  input  logic        mem_data_next,
  input  logic [31:0] mem_rd_data,
  output logic [24:0] mem_rd_addr,
  output logic        mem_rd_req,
  input  logic [9:0]  fifo_usedw,
  output logic [31:0] pix_data,
  output logic        pix_wr,
  output logic        fifo_clr,
  output logic        frame_done,
  output logic        err_stray
);

  localparam int             BCW       = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [BCW-1:0] BCNT_LAST = BCW'(BURST_LEN - 1);
  localparam logic [17:0]    WCNT_LAST = 18'(FRAME_WORDS - 1);
  localparam logic [10:0]    FILL_LIM  = 11'(FILL_LIMIT);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_SPACE,
    WAIT_IDLE,
    REQ,
    READ,
    DONE
  } state_t;

  state_t         state_q, state_d;
  logic           req_q, req_d;
  logic [24:0]    addr_q, addr_d;
  logic [17:0]    wcnt_q, wcnt_d;
  logic [BCW-1:0] bcnt_q, bcnt_d;
  logic           pix_wr_q, pix_wr_d;
  logic [31:0]    pix_data_q, pix_data_d;
  logic           clr_q, clr_d;
  logic           done_q, done_d;
  logic           stray_q, stray_d;
  logic           pend_q, pend_d;

  logic           space_ok;
  logic           pend_eff;
  logic           restart;

  assign space_ok = ({1'b0, fifo_usedw} < FILL_LIM);
  // A frame_start arriving together with a burst word already counts as
  // pending, so that word is suppressed as well.
  assign pend_eff = pend_q | frame_start;

  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    addr_d     = addr_q;
    wcnt_d     = wcnt_q;
    bcnt_d     = bcnt_q;
    pix_wr_d   = 1'b0;
    pix_data_d = pix_data_q;
    clr_d      = 1'b0;
    done_d     = done_q;
    stray_d    = stray_q;
    pend_d     = pend_q;
    restart    = 1'b0;

    if (mem_data_next && (state_q != READ)) begin
      stray_d = 1'b1;
    end

    unique case (state_q)
      IDLE, DONE: begin
        if (frame_start) begin
          restart = 1'b1;
        end
      end

      WAIT_SPACE: begin
        if (frame_start) begin
          restart = 1'b1;
        end else if (space_ok) begin
          state_d = WAIT_IDLE;
        end
      end

      WAIT_IDLE: begin
        if (frame_start) begin
          restart = 1'b1;
        end else if (mem_idle) begin
          state_d = REQ;
          req_d   = 1'b1;
        end
      end

      REQ: begin
        if (frame_start) begin
          pend_d = 1'b1;
        end
        if (mem_ack) begin
          req_d   = 1'b0;
          bcnt_d  = '0;
          state_d = READ;
        end
      end

      READ: begin
        if (frame_start) begin
          pend_d = 1'b1;
        end
        if (mem_data_next) begin
          if (!pend_eff) begin
            pix_wr_d   = 1'b1;
            pix_data_d = mem_rd_data;
          end
          bcnt_d = bcnt_q + 1'b1;
          wcnt_d = wcnt_q + 18'd1;
          addr_d = addr_q + 25'd1;
          if (bcnt_q == BCNT_LAST) begin
            bcnt_d = '0;
            if (pend_eff) begin
              restart = 1'b1;
            end else if (wcnt_q == WCNT_LAST) begin
              state_d = DONE;
              done_d  = 1'b1;
              addr_d  = BASE_ADDR;
            end else begin
              state_d = WAIT_SPACE;
            end
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Restart also covers the drained-burst case; the flush pulse goes out
    // in the cycle WAIT_SPACE is entered, so no request can overlap it.
    if (restart) begin
      clr_d   = 1'b1;
      addr_d  = BASE_ADDR;
      wcnt_d  = '0;
      done_d  = 1'b0;
      pend_d  = 1'b0;
      state_d = WAIT_SPACE;
    end
  end

  always_ff @(posedge mem_clk) begin
    if (reset) begin
      state_q    <= IDLE;
      req_q      <= 1'b0;
      addr_q     <= BASE_ADDR;
      wcnt_q     <= '0;
      bcnt_q     <= '0;
      pix_wr_q   <= 1'b0;
      pix_data_q <= '0;
      clr_q      <= 1'b0;
      done_q     <= 1'b0;
      stray_q    <= 1'b0;
      pend_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
      wcnt_q     <= wcnt_d;
      bcnt_q     <= bcnt_d;
      pix_wr_q   <= pix_wr_d;
      pix_data_q <= pix_data_d;
      clr_q      <= clr_d;
      done_q     <= done_d;
      stray_q    <= stray_d;
      pend_q     <= pend_d;
    end
  end

  assign mem_rd_addr = addr_q;
  assign mem_rd_req  = req_q;
  assign pix_data    = pix_data_q;
  assign pix_wr      = pix_wr_q;
  assign fifo_clr    = clr_q;
  assign frame_done  = done_q;
  assign err_stray   = stray_q;

endmodule

// File: tb/tb_vga_frame_fetcher.sv
// Bench for vga_frame_fetcher: directed scenarios followed by randomized
// traffic, with a reference model checked against the DUT every cycle.

module tb_vga_frame_fetcher;

  localparam logic [24:0] BASE = 25'h0001230;
  localparam int          FW   = 8;
  localparam int          BL   = 4;
  localparam int          LIM  = 1000;

  logic        mem_clk       = 1'b0;
  logic        reset         = 1'b1;
  logic        frame_start   = 1'b0;
  logic        mem_idle      = 1'b1;
  logic        mem_ack       = 1'b0;
  logic        mem_data_next = 1'b0;
  logic [31:0] mem_rd_data   = '0;
  logic [9:0]  fifo_usedw    = '0;
  logic [24:0] mem_rd_addr;
  logic        mem_rd_req;
  logic [31:0] pix_data;
  logic        pix_wr;
  logic        fifo_clr;
  logic        frame_done;
  logic        err_stray;

  vga_frame_fetcher #(
    .BASE_ADDR  (BASE),
    .FRAME_WORDS(FW),
    .BURST_LEN  (BL),
    .FILL_LIMIT (LIM)
  ) dut (
    .mem_clk      (mem_clk),
    .reset        (reset),
    .frame_start  (frame_start),
    .mem_idle     (mem_idle),
    .mem_ack      (mem_ack),
    .mem_data_next(mem_data_next),
    .mem_rd_data  (mem_rd_data),
    .mem_rd_addr  (mem_rd_addr),
    .mem_rd_req   (mem_rd_req),
    .fifo_usedw   (fifo_usedw),
    .pix_data     (pix_data),
    .pix_wr       (pix_wr),
    .fifo_clr     (fifo_clr),
    .frame_done   (frame_done),
    .err_stray    (err_stray)
  );

  always #5 mem_clk = ~mem_clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // The address is always "base + words fetched in this frame" (or base once
  // the frame is complete); a burst ends whenever the fetched count reaches a
  // multiple of the burst length.
  localparam int P_OFF = 0, P_SPACE = 1, P_IDLEWAIT = 2, P_ASK = 3, P_BURST = 4;

  bit          m_valid = 1'b0;
  int          m_phase;
  int          m_fetched;
  bit          m_pend;
  bit          e_req, e_wr, e_clr, e_done, e_stray;
  logic [31:0] e_data;

  always @(posedge mem_clk) begin
    bit restart;
    restart = 1'b0;
    e_wr    = 1'b0;
    e_clr   = 1'b0;
    if (reset) begin
      m_valid   = 1'b1;
      m_phase   = P_OFF;
      m_fetched = 0;
      m_pend    = 1'b0;
      e_req     = 1'b0;
      e_done    = 1'b0;
      e_stray   = 1'b0;
      e_data    = '0;
    end else if (m_valid) begin
      if (mem_data_next && m_phase != P_BURST) e_stray = 1'b1;
      case (m_phase)
        P_OFF:      restart = frame_start;
        P_SPACE: begin
          if (frame_start) restart = 1'b1;
          else if (int'(fifo_usedw) < LIM) m_phase = P_IDLEWAIT;
        end
        P_IDLEWAIT: begin
          if (frame_start) restart = 1'b1;
          else if (mem_idle) begin
            m_phase = P_ASK;
            e_req   = 1'b1;
          end
        end
        P_ASK: begin
          if (frame_start) m_pend = 1'b1;
          if (mem_ack) begin
            e_req   = 1'b0;
            m_phase = P_BURST;
          end
        end
        default: begin
          if (frame_start) m_pend = 1'b1;
          if (mem_data_next) begin
            if (!m_pend) begin
              e_wr   = 1'b1;
              e_data = mem_rd_data;
            end
            m_fetched++;
            if (m_fetched % BL == 0) begin
              if (m_pend) restart = 1'b1;
              else if (m_fetched == FW) begin
                e_done  = 1'b1;
                m_phase = P_OFF;
              end else m_phase = P_SPACE;
            end
          end
        end
      endcase
      if (restart) begin
        e_clr     = 1'b1;
        e_done    = 1'b0;
        m_pend    = 1'b0;
        m_fetched = 0;
        m_phase   = P_SPACE;
      end
    end
  end

  // ---------------- compare + monitor ----------------
  int          n_wr = 0, n_clr = 0, req_hi = 0;
  bit          prev_req = 1'b0;
  logic [31:0] wr_q[$];
  logic [24:0] req_addr_q[$];

  always @(negedge mem_clk) begin
    if (m_valid) begin
      chk("req", mem_rd_req, e_req);
      chk("addr", mem_rd_addr, e_done ? BASE : BASE + 25'(m_fetched));
      chk("pix_wr", pix_wr, e_wr);
      if (e_wr) chk("pix_data", pix_data, e_data);
      chk("fifo_clr", fifo_clr, e_clr);
      chk("frame_done", frame_done, e_done);
      chk("err_stray", err_stray, e_stray);
      if (pix_wr) begin
        n_wr++;
        wr_q.push_back(pix_data);
      end
      if (fifo_clr) n_clr++;
      if (mem_rd_req) req_hi++;
      if (mem_rd_req && !prev_req) req_addr_q.push_back(mem_rd_addr);
      prev_req = mem_rd_req;
    end
  end

  // ---------------- controller / stimulus ----------------
  int          r_wait    = 1;
  int          r_left    = 0;
  int          ack_delay = 1;
  int          gap_pct   = 0;
  bit          rand_mode = 1'b0;
  bit          stray_req = 1'b0;
  logic [31:0] deliv_q[$];

  task automatic step();
    @(negedge mem_clk);
    #1;
    mem_ack       = 1'b0;
    mem_data_next = 1'b0;
    if (rand_mode) begin
      mem_idle   = ($urandom_range(99) < 70);
      fifo_usedw = ($urandom_range(99) < 75) ? 10'($urandom_range(LIM - 1))
                                             : 10'($urandom_range(1023, LIM - 3));
      ack_delay  = $urandom_range(3);
      gap_pct    = 30;
    end
    if (r_left > 0) begin
      if ($urandom_range(99) >= gap_pct) begin
        mem_data_next = 1'b1;
        mem_rd_data   = $urandom;
        deliv_q.push_back(mem_rd_data);
        r_left--;
      end
    end else if (mem_rd_req) begin
      if (r_wait == 0) begin
        mem_ack = 1'b1;
        r_left  = BL;
      end else r_wait--;
    end else begin
      r_wait = ack_delay;
      if (stray_req) begin
        mem_data_next = 1'b1;
        mem_rd_data   = $urandom;
        stray_req     = 1'b0;
      end else if (rand_mode && $urandom_range(299) == 0) begin
        mem_data_next = 1'b1;
        mem_rd_data   = $urandom;
      end else if (rand_mode && $urandom_range(199) == 0) begin
        mem_ack = 1'b1;
      end
    end
  endtask

  task automatic pulse_start();
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
  endtask

  task automatic do_reset();
    reset         = 1'b1;
    r_left        = 0;
    mem_ack       = 1'b0;
    mem_data_next = 1'b0;
    step();
    step();
  endtask

  task automatic wait_done(string tag);
    int k;
    k = 0;
    while (!frame_done && k < 400) begin
      step();
      k++;
    end
    chk({tag, "_done"}, frame_done, 1'b1);
  endtask

  task automatic check_reset_vals(string tag);
    chk({tag, "_req"}, mem_rd_req, 1'b0);
    chk({tag, "_addr"}, mem_rd_addr, BASE);
    chk({tag, "_wr"}, pix_wr, 1'b0);
    chk({tag, "_data"}, pix_data, 32'h0);
    chk({tag, "_clr"}, fifo_clr, 1'b0);
    chk({tag, "_done"}, frame_done, 1'b0);
    chk({tag, "_stray"}, err_stray, 1'b0);
  endtask

  initial begin
    int base_wr, base_clr, base_hi, cnt;

    // reset values
    do_reset();
    check_reset_vals("rst");
    reset = 1'b0;

    // one full frame: 2 bursts of 4
    step();
    wr_q.delete();
    deliv_q.delete();
    req_addr_q.delete();
    base_wr  = n_wr;
    base_clr = n_clr;
    pulse_start();
    wait_done("t1");
    chk("t1_nreq", req_addr_q.size(), 2);
    if (req_addr_q.size() == 2) begin
      chk("t1_addr0", req_addr_q[0], BASE);
      chk("t1_addr1", req_addr_q[1], BASE + 25'd4);
    end
    chk("t1_nwr", n_wr - base_wr, 8);
    chk("t1_nclr", n_clr - base_clr, 1);
    chk("t1_ndeliv", deliv_q.size(), 8);
    if (wr_q.size() == 8 && deliv_q.size() == 8) begin
      for (int i = 0; i < 8; i++) chk("t1_word", wr_q[i], deliv_q[i]);
    end

    // fill-level throttle
    fifo_usedw = 10'(LIM);
    base_hi    = req_hi;
    pulse_start();
    for (int i = 0; i < 30; i++) step();
    chk("t2_noreq", req_hi - base_hi, 0);
    fifo_usedw = 10'(LIM - 1);
    cnt = 0;
    while (!mem_rd_req && cnt < 10) begin
      step();
      cnt++;
    end
    chk("t2_latency", cnt, 2);
    fifo_usedw = '0;
    wait_done("t2");

    // controller busy, then ack after a longer delay
    ack_delay = 3;
    mem_idle  = 1'b0;
    base_hi   = req_hi;
    pulse_start();
    for (int i = 0; i < 20; i++) step();
    chk("t3_noreq", req_hi - base_hi, 0);
    mem_idle = 1'b1;
    cnt = 0;
    while (!mem_rd_req && cnt < 10) begin
      step();
      cnt++;
    end
    cnt = 0;
    while (mem_rd_req && cnt < 20) begin
      step();
      cnt++;
    end
    chk("t3_req_len", req_hi - base_hi, 4);
    ack_delay = 1;
    wait_done("t3");

    // frame_start during word 2 of the first burst
    base_wr  = n_wr;
    base_clr = n_clr;
    pulse_start();
    cnt = 0;
    while (!(mem_data_next && r_left == 1) && cnt < 50) begin
      step();
      cnt++;
    end
    chk("t4_reached_w2", r_left, 1);
    req_addr_q.delete();
    pulse_start();
    cnt = 0;
    while (req_addr_q.size() == 0 && cnt < 50) begin
      step();
      cnt++;
    end
    chk("t4_nwr", n_wr - base_wr, 2);
    chk("t4_nclr", n_clr - base_clr, 2);
    chk("t4_nreq", req_addr_q.size(), 1);
    if (req_addr_q.size() > 0) chk("t4_addr", req_addr_q[0], BASE);
    wait_done("t4");

    // stray data in IDLE
    do_reset();
    reset = 1'b0;
    step();
    chk("t5_pre", err_stray, 1'b0);
    base_wr   = n_wr;
    stray_req = 1'b1;
    step();
    step();
    for (int i = 0; i < 5; i++) begin
      chk("t5_stray", err_stray, 1'b1);
      step();
    end
    chk("t5_nwr", n_wr - base_wr, 0);

    // reset in the middle of a burst
    pulse_start();
    cnt = 0;
    while (r_left != 2 && cnt < 50) begin
      step();
      cnt++;
    end
    reset         = 1'b1;
    r_left        = 0;
    mem_ack       = 1'b0;
    mem_data_next = 1'b0;
    step();
    check_reset_vals("t6");
    reset = 1'b0;
    req_addr_q.delete();
    pulse_start();
    cnt = 0;
    while (req_addr_q.size() == 0 && cnt < 50) begin
      step();
      cnt++;
    end
    chk("t6_nreq", req_addr_q.size(), 1);
    if (req_addr_q.size() > 0) chk("t6_addr", req_addr_q[0], BASE);
    wait_done("t6");

    // randomized traffic
    rand_mode = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(999) < 3) begin
        reset  = 1'b1;
        r_left = 0;
        step();
        reset = 1'b0;
      end else begin
        frame_start = ($urandom_range(99) < 2);
        step();
        frame_start = 1'b0;
      end
    end
    rand_mode = 1'b0;
    step();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
